// File: rtl/preserving_reg_file.sv
// preserving_reg_file
//   Multi-ported register file with one write port, two combinational read
//   ports and a per-register "busy" scoreboard bit. One index is hardwired to
//   zero. Writes to that index, or to indices >= DEPTH, are dropped.
//   Optional write-to-read forwarding is controlled by BYPASS.
//
// Parameters
//   WIDTH    data bits per register
//   DEPTH    number of registers (>= 2)
//   ZERO_REG index that always reads zero and is never written or reserved
//   BYPASS   1 = read ports forward wr_data on an address match, 0 = no forwarding
//
// Ports
//   clk                     single clock, all state updates on rising edge
//   reset                   synchronous, active-high; clears data and busy bits
//   wr_en/wr_addr/wr_data   write request; a completed write clears busy
//   rd_addr_a/rd_addr_b     read selects
//   rd_data_a/rd_data_b     combinational read data
//   rsv_en/rsv_addr         reserve request; sets busy on the next edge
//   busy_a/busy_b           registered busy bit of rd_addr_a / rd_addr_b
module preserving_reg_file #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             busy_a,
  output logic             busy_b
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wr_ok;
  logic rsv_ok;
  logic rd_ok_a;
  logic rd_ok_b;

  // An index is usable only if it exists and is not the hardwired zero slot.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && (32'(a) != ZERO_REG);
  endfunction

  assign wr_ok   = wr_en && addr_ok(wr_addr);
  assign rsv_ok  = rsv_en && addr_ok(rsv_addr);
  assign rd_ok_a = addr_ok(rd_addr_a);
  assign rd_ok_b = addr_ok(rd_addr_b);

  // Data storage. Unwritten registers simply hold their value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Busy scoreboard. The reserve assignment comes after the write-clear so
  // that when both hit the same register on one edge, the reservation wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wr_ok) begin
        busy[wr_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  // Read port A. An address match with a valid read index implies the write
  // index is valid too, so no separate wr_ok term is needed for forwarding.
  always_comb begin
    rd_data_a = '0;
    busy_a    = 1'b0;
    if (rd_ok_a) begin
      busy_a = busy[rd_addr_a];
      if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = regs[rd_addr_a];
      end
    end
  end

  // Read port B, identical to port A.
  always_comb begin
    rd_data_b = '0;
    busy_b    = 1'b0;
    if (rd_ok_b) begin
      busy_b = busy[rd_addr_b];
      if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = regs[rd_addr_b];
      end
    end
  end

endmodule

// File: tb/tb_preserving_reg_file.sv
// tb_preserving_reg_file
//   Directed bench for preserving_reg_file. Three instances share one set of
//   inputs: default build (BYPASS=1, DEPTH=32), a no-forwarding build
//   (BYPASS=0) and a short build (DEPTH=24).
module tb_preserving_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [63:0] rd_data_a,   rd_data_b;
  logic        busy_a,      busy_b;
  logic [63:0] nb_rd_data_a, nb_rd_data_b;
  logic        nb_busy_a,   nb_busy_b;
  logic [63:0] sh_rd_data_a, sh_rd_data_b;
  logic        sh_busy_a,   sh_busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  preserving_reg_file dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  preserving_reg_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(nb_busy_a), .busy_b(nb_busy_b)
  );

  preserving_reg_file #(.DEPTH(24)) dut_sh (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(sh_rd_data_a), .rd_data_b(sh_rd_data_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_a(sh_busy_a), .busy_b(sh_busy_b)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive every input, then let combinational reads settle.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                               input logic re, input logic [4:0] ra,
                               input logic [4:0] rda, input logic [4:0] rdb);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsv_en    = re;
    rsv_addr  = ra;
    rd_addr_a = rda;
    rd_addr_b = rdb;
    #1;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd17);
    step();
    step();
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_rd_a", rd_data_a, 64'h0);
    checkOutput("rst_rd_b", rd_data_b, 64'h0);
    checkOutput("rst_busy_a", {63'h0, busy_a}, 64'h0);
    checkOutput("rst_busy_b", {63'h0, busy_b}, 64'h0);

    // Hold: reg3 keeps its value through idle cycles
    applyStimulus(1'b1, 5'd3, 64'hDEAD_BEEF, 1'b0, 5'd0, 5'd3, 5'd3);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    checkOutput("hold_0", rd_data_a, 64'hDEAD_BEEF);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput($sformatf("hold_%0d", i), rd_data_a, 64'hDEAD_BEEF);
    end
    checkOutput("hold_busy", {63'h0, busy_a}, 64'h0);

    // Zero register: write and read index 31 on both ports
    applyStimulus(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 5'd31, 5'd31);
    checkOutput("zero_same_a", rd_data_a, 64'h0);
    checkOutput("zero_same_b", rd_data_b, 64'h0);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd31, 5'd31);
    checkOutput("zero_next_a", rd_data_a, 64'h0);
    checkOutput("zero_next_b", rd_data_b, 64'h0);
    checkOutput("zero_busy_a", {63'h0, busy_a}, 64'h0);

    // Bypass vs. no bypass on reg5
    applyStimulus(1'b1, 5'd5, 64'h11, 1'b0, 5'd0, 5'd5, 5'd5);
    step();
    applyStimulus(1'b1, 5'd5, 64'h22, 1'b0, 5'd0, 5'd5, 5'd5);
    checkOutput("byp_n_a", rd_data_a, 64'h22);
    checkOutput("byp_n_b", rd_data_b, 64'h22);
    checkOutput("nobyp_n_a", nb_rd_data_a, 64'h11);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd3);
    checkOutput("byp_n1_a", rd_data_a, 64'h22);
    checkOutput("nobyp_n1_a", nb_rd_data_a, 64'h22);
    checkOutput("two_ports_b", rd_data_b, 64'hDEAD_BEEF);

    // Scoreboard on reg7
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd7, 5'd7);
    checkOutput("sb_n_busy", {63'h0, busy_a}, 64'h0);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("sb_n1_busy", {63'h0, busy_a}, 64'h1);
    step();
    checkOutput("sb_n2_busy", {63'h0, busy_b}, 64'h1);
    step();
    applyStimulus(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("sb_n3_busy", {63'h0, busy_a}, 64'h1);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("sb_n4_busy", {63'h0, busy_a}, 64'h0);
    checkOutput("sb_n4_data", rd_data_a, 64'h77);
    applyStimulus(1'b1, 5'd7, 64'h78, 1'b1, 5'd7, 5'd7, 5'd7);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("sb_both_data", rd_data_a, 64'h78);
    checkOutput("sb_both_busy", {63'h0, busy_a}, 64'h1);

    // Reserve and write different registers on one edge
    applyStimulus(1'b1, 5'd9, 64'h99, 1'b1, 5'd8, 5'd8, 5'd9);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd8, 5'd9);
    checkOutput("diff_busy8", {63'h0, busy_a}, 64'h1);
    checkOutput("diff_busy9", {63'h0, busy_b}, 64'h0);
    checkOutput("diff_data9", rd_data_b, 64'h99);

    // Re-reserve busy reg8, write non-busy reg10, reserve the zero register
    applyStimulus(1'b1, 5'd10, 64'hA0, 1'b1, 5'd8, 5'd8, 5'd10);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 5'd8, 5'd10);
    checkOutput("rersv_busy8", {63'h0, busy_a}, 64'h1);
    checkOutput("wr_nonbusy10", {63'h0, busy_b}, 64'h0);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd31, 5'd10);
    checkOutput("rsv_zero_busy", {63'h0, busy_a}, 64'h0);

    // Reset mid-operation: reg1, reg2 written, reg2 busy
    applyStimulus(1'b1, 5'd1, 64'h1, 1'b0, 5'd0, 5'd1, 5'd2);
    step();
    applyStimulus(1'b1, 5'd2, 64'h2, 1'b0, 5'd0, 5'd1, 5'd2);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd2, 5'd1, 5'd2);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd1, 5'd2);
    checkOutput("pre_rst_r1", rd_data_a, 64'h1);
    checkOutput("pre_rst_busy2", {63'h0, busy_b}, 64'h1);
    reset = 1'b1;
    applyStimulus(1'b1, 5'd1, 64'hAB, 1'b1, 5'd4, 5'd1, 5'd2);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd1, 5'd2);
    checkOutput("mid_rst_r1", rd_data_a, 64'h0);
    checkOutput("mid_rst_r2", rd_data_b, 64'h0);
    checkOutput("mid_rst_busy1", {63'h0, busy_a}, 64'h0);
    checkOutput("mid_rst_busy2", {63'h0, busy_b}, 64'h0);
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    checkOutput("mid_rst_r3", rd_data_a, 64'h0);
    checkOutput("mid_rst_busy4", {63'h0, busy_b}, 64'h0);

    // Range: DEPTH=24 build ignores index 30, still uses index 23
    applyStimulus(1'b1, 5'd30, 64'h5, 1'b0, 5'd0, 5'd30, 5'd30);
    checkOutput("range_byp", sh_rd_data_a, 64'h0);
    step();
    applyStimulus(1'b1, 5'd23, 64'h23, 1'b1, 5'd30, 5'd30, 5'd23);
    step();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd30, 5'd23);
    checkOutput("range_rd30", sh_rd_data_a, 64'h0);
    checkOutput("range_busy30", {63'h0, sh_busy_a}, 64'h0);
    checkOutput("range_rd23", sh_rd_data_b, 64'h23);
    checkOutput("range_full30", rd_data_a, 64'h5);
    checkOutput("range_full_busy30", {63'h0, busy_a}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
